ballot_unit: RTL and testbench
==============================

BALLOT_UNIT -- requirements
Module: ballot_unit

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronized cycles before a button level change is accepted.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, armed-ballot lifetime in cycles (used only with BALLOT_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports btn_1, btn_2, btn_3  input  1 each  raw asynchronous candidate buttons, high = pressed.
REQ-006 SHALL have port ballot_issue  input  1  officer request to arm one ballot.
REQ-007 SHALL have ports out_candidate_1, out_candidate_2, out_candidate_3  output  1 each  single-cycle vote pulses to the downstream vote counter.
REQ-008 SHALL have port ballot_armed  output  1  high while a ballot is open (ARMED state).
REQ-009 SHALL have port vote_accepted  output  1  one-cycle pulse coincident with any out_candidate pulse.
REQ-010 SHALL have port vote_rejected  output  1  one-cycle pulse on multi-button press.
REQ-011 SHALL have port ballot_timeout  output  1  one-cycle pulse on armed-ballot expiry.
REQ-012 SHALL have port ballots_cast  output  8  count of accepted votes since reset.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then a debouncer: debounced level flips only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter.
REQ-014 Rising edges SHALL be detected on debounced levels (registered previous level).
REQ-015 FSM states SHALL be IDLE, ARMED, WAIT_RELEASE, REJECT_RELEASE.
REQ-016 IDLE: ballot_issue=1 with all debounced buttons low -> ARMED next cycle; ballot_issue with any button held SHALL be ignored.
REQ-017 ARMED: exactly one debounced rising edge and other two debounced levels low -> in the next cycle, pulse matching out_candidate_x and vote_accepted for one cycle, increment ballots_cast, enter WAIT_RELEASE.
REQ-018 ARMED: two or more debounced levels high while any rising edge occurs (simultaneous or overlapping presses) -> one-cycle vote_rejected in the next cycle, no out_candidate pulse, enter REJECT_RELEASE.
REQ-019 WAIT_RELEASE -> IDLE when all debounced levels low; REJECT_RELEASE -> ARMED when all debounced levels low.
REQ-020 ballot_issue SHALL be ignored in all states except IDLE; at most one accepted vote per issued ballot.
REQ-021 ballots_cast SHALL saturate at 255 (no wrap); out_candidate pulses continue after saturation.
REQ-022 All outputs SHALL be registered; at most one of out_candidate_1..3 high in any cycle.
REQ-023 Button pressed in IDLE and held into ARMED SHALL not vote (no rising edge in ARMED).

Reset
REQ-024 reset SHALL force state IDLE, all outputs 0, ballots_cast 0, synchronizers, debounced levels and counters 0, effective the cycle after reset is sampled high, including mid-debounce or mid-ballot.

Configuration
REQ-025 With macro BALLOT_TIMEOUT_EN defined, ARMED SHALL count cycles from entry and, after TIMEOUT_CYCLES cycles without a vote or reject, pulse ballot_timeout one cycle and return to IDLE; counter restarts on every ARMED entry.
REQ-026 Without BALLOT_TIMEOUT_EN, ballot_timeout SHALL be tied 0 and ARMED SHALL wait indefinitely.

Structure
REQ-027 Shared package ballot_pkg SHALL hold the FSM state encoding, vote-count width (8) and saturation constant.
REQ-028 Sub-module btn_debounce (synchronizer + debouncer, DEBOUNCE_CYCLES parameter) SHALL be instantiated three times.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 ballot_issue pulse, btn_2 high 10 cycles -> ballot_armed high, exactly one out_candidate_2 + vote_accepted pulse, ballots_cast 0->1, IDLE after release.
REQ-030 btn_1 glitch high 3 cycles while ARMED -> no pulse, still ARMED.
REQ-031 btn_1 and btn_3 raised same cycle while ARMED -> one vote_rejected, no out_candidate, ballots_cast unchanged, ARMED after both released.
REQ-032 Second press after accepted vote without new ballot_issue -> no pulse; ballot_issue while btn_1 held -> ignored.
REQ-033 256 accepted ballots -> ballots_cast stays 255; reset mid-WAIT_RELEASE -> IDLE, ballots_cast 0.
REQ-034 BALLOT_TIMEOUT_EN, TIMEOUT_CYCLES=20, no press -> ballot_timeout pulse 20 cycles after ARMED entry, IDLE; without macro stays ARMED at cycle 100.

Source files
------------

// File: rtl/ballot_pkg.sv
// ballot_pkg: shared FSM state encoding and vote-count constants for ballot_unit.
package ballot_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, WAIT_RELEASE, REJECT_RELEASE} state_t;
  localparam int VOTE_W = 8;
  localparam logic [VOTE_W-1:0] VOTE_MAX = '1;
  function automatic logic [1:0] btn_count(input logic [2:0] b);
    return 2'(b[0]) + 2'(b[1]) + 2'(b[2]);
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer followed by a consecutive-cycle debouncer.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync[1];
      end else cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/ballot_unit.sv
// ballot_unit: arms one ballot per officer request and forwards a single debounced vote.
// Optional armed-ballot expiry is built when BALLOT_TIMEOUT_EN is defined.
module ballot_unit
  import ballot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_1,
  input  logic              btn_2,
  input  logic              btn_3,
  input  logic              ballot_issue,
  output logic              out_candidate_1,
  output logic              out_candidate_2,
  output logic              out_candidate_3,
  output logic              ballot_armed,
  output logic              vote_accepted,
  output logic              vote_rejected,
  output logic              ballot_timeout,
  output logic [VOTE_W-1:0] ballots_cast
);
  state_t state, state_n;
  logic [2:0] raw, lvl, prev, rise, vote_n;
  logic acc_n, rej_n, to_n, tmo;
  assign raw  = {btn_3, btn_2, btn_1};
  assign rise = lvl & ~prev;
  for (genvar i = 0; i < 3; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .btn   (raw[i]),
      .level (lvl[i])
    );
  end
`ifdef BALLOT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr;
  // Held at zero outside ARMED so every entry restarts the lifetime.
  always_ff @(posedge clk) tmr <= (reset || state != ARMED) ? '0 : tmr + TW'(1);
  assign tmo = tmr == TW'(TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_n = state;
    vote_n  = '0;
    acc_n   = 1'b0;
    rej_n   = 1'b0;
    to_n    = 1'b0;
    case (state)
      IDLE: state_n = (ballot_issue && lvl == '0) ? ARMED : IDLE;
      ARMED:
        if (|rise) begin
          rej_n   = btn_count(lvl) > 2'd1;
          acc_n   = !rej_n;
          vote_n  = rej_n ? 3'b000 : rise;
          state_n = rej_n ? REJECT_RELEASE : WAIT_RELEASE;
        end else if (tmo) begin
          to_n    = 1'b1;
          state_n = IDLE;
        end
      WAIT_RELEASE:   state_n = (lvl == '0) ? IDLE : WAIT_RELEASE;
      REJECT_RELEASE: state_n = (lvl == '0) ? ARMED : REJECT_RELEASE;
      default:        state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      prev            <= '0;
      out_candidate_1 <= 1'b0;
      out_candidate_2 <= 1'b0;
      out_candidate_3 <= 1'b0;
      ballot_armed    <= 1'b0;
      vote_accepted   <= 1'b0;
      vote_rejected   <= 1'b0;
      ballot_timeout  <= 1'b0;
      ballots_cast    <= '0;
    end else begin
      state           <= state_n;
      prev            <= lvl;
      out_candidate_1 <= vote_n[0];
      out_candidate_2 <= vote_n[1];
      out_candidate_3 <= vote_n[2];
      ballot_armed    <= state_n == ARMED;
      vote_accepted   <= acc_n;
      vote_rejected   <= rej_n;
      ballot_timeout  <= to_n;
      if (acc_n && ballots_cast != VOTE_MAX) ballots_cast <= ballots_cast + VOTE_W'(1);
    end
  end
endmodule

// File: tb/tb_ballot_unit.sv
// tb_ballot_unit: scoreboard bench for ballot_unit against a behavioural model.
module tb_ballot_unit;
  localparam int DB = 4;
  localparam int TO = 20;
`ifdef BALLOT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, ballot_issue = 1'b0;
  logic [2:0] btn = '0;
  logic oc1, oc2, oc3, ballot_armed, vote_accepted, vote_rejected, ballot_timeout;
  logic [7:0] ballots_cast;

  ballot_unit #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .reset           (reset),
    .btn_1           (btn[0]),
    .btn_2           (btn[1]),
    .btn_3           (btn[2]),
    .ballot_issue    (ballot_issue),
    .out_candidate_1 (oc1),
    .out_candidate_2 (oc2),
    .out_candidate_3 (oc3),
    .ballot_armed    (ballot_armed),
    .vote_accepted   (vote_accepted),
    .vote_rejected   (vote_rejected),
    .ballot_timeout  (ballot_timeout),
    .ballots_cast    (ballots_cast)
  );

  always #5 clk = ~clk;

  typedef struct {int c; logic [2:0] cand; logic acc; logic rej; logic to;} ev_t;
  ev_t exp_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, n_c2 = 0, n_to = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Reference model: raw samples reach the debouncer two edges late; a level
  // flips after DB consecutive disagreeing samples; ballot phases as flags.
  logic [2:0] m_lvl = '0, m_prev = '0;
  logic [2:0] rawq[$] = '{3'b000, 3'b000};
  int streak[3] = '{0, 0, 0};
  bit m_open = 0, m_wait = 0, m_rej = 0;
  int m_age = 0, m_cast = 0;

  always @(posedge clk) begin : model
    logic [2:0] rise, synced;
    int held;
    ev_t e;
    cyc++;
    if (reset) begin
      m_lvl = '0; m_prev = '0; rawq = '{3'b000, 3'b000}; streak = '{0, 0, 0};
      m_open = 0; m_wait = 0; m_rej = 0; m_age = 0; m_cast = 0;
    end else begin
      rise = m_lvl & ~m_prev;
      held = $countones(m_lvl);
      if (m_open) begin
        m_age++;
        if (rise != 0) begin
          m_open = 0;
          e = '{cyc, 3'b000, 1'b0, 1'b0, 1'b0};
          if (held >= 2) begin
            m_rej = 1; e.rej = 1'b1;
          end else begin
            m_wait = 1; e.acc = 1'b1; e.cand = rise;
            m_cast = (m_cast < 255) ? m_cast + 1 : 255;
          end
          exp_q.push_back(e);
        end else if (TO_EN && m_age == TO) begin
          m_open = 0;
          e = '{cyc, 3'b000, 1'b0, 1'b0, 1'b1};
          exp_q.push_back(e);
        end
      end else if (m_wait) m_wait = (m_lvl != 0);
      else if (m_rej) begin
        if (m_lvl == 0) begin m_rej = 0; m_open = 1; m_age = 0; end
      end else if (ballot_issue && m_lvl == 0) begin
        m_open = 1; m_age = 0;
      end
      m_prev = m_lvl;
      synced = rawq.pop_front();
      rawq.push_back(btn);
      for (int b = 0; b < 3; b++)
        if (synced[b] != m_lvl[b]) begin
          streak[b]++;
          if (streak[b] == DB) begin m_lvl[b] = synced[b]; streak[b] = 0; end
        end else streak[b] = 0;
    end
  end

  always @(negedge clk) begin : monitor
    logic pulse, exp_now;
    ev_t e;
    if (cyc > 0) begin
      pulse = oc1 | oc2 | oc3 | vote_accepted | vote_rejected | ballot_timeout;
      n_c2 += int'(oc2);
      n_to += int'(ballot_timeout);
      exp_now = exp_q.size() > 0 && exp_q[0].c == cyc;
      chk("pulse_present", int'(pulse), int'(exp_now));
      if (exp_now) begin
        e = exp_q.pop_front();
        chk("candidate", int'({oc3, oc2, oc1}), int'(e.cand));
        chk("vote_accepted", int'(vote_accepted), int'(e.acc));
        chk("vote_rejected", int'(vote_rejected), int'(e.rej));
        chk("ballot_timeout", int'(ballot_timeout), int'(e.to));
      end
      chk("ballot_armed", int'(ballot_armed), int'(m_open));
      chk("ballots_cast", int'(ballots_cast), m_cast);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue_pulse();
    ballot_issue = 1'b1;
    tick(1);
    ballot_issue = 1'b0;
  endtask

  initial begin
    tick(3);
    chk("rst_armed", int'(ballot_armed), 0);
    chk("rst_cast", int'(ballots_cast), 0);
    chk("rst_pulses", int'({oc1, oc2, oc3, vote_accepted, vote_rejected, ballot_timeout}), 0);
    reset = 1'b0;
    tick(2);
    issue_pulse();
    btn = 3'b010; tick(10);
    btn = 3'b000; tick(10);
    chk("vote1_cast", int'(ballots_cast), 1);
    chk("vote1_idle", int'(ballot_armed), 0);
    chk("vote1_c2_pulses", n_c2, 1);
    issue_pulse();
    btn = 3'b001; tick(3);
    btn = 3'b000; tick(6);
    chk("glitch_armed", int'(ballot_armed), 1);
    chk("glitch_cast", int'(ballots_cast), 1);
    btn = 3'b101; tick(10);
    chk("rej_cast", int'(ballots_cast), 1);
    chk("rej_disarmed", int'(ballot_armed), 0);
    btn = 3'b000; tick(8);
    chk("rej_rearmed", int'(ballot_armed), 1);
    btn = 3'b100; tick(8);
    btn = 3'b000; tick(10);
    chk("vote2_cast", int'(ballots_cast), 2);
    btn = 3'b001; tick(10);
    btn = 3'b000; tick(10);
    chk("no_reissue_cast", int'(ballots_cast), 2);
    btn = 3'b001; tick(8);
    issue_pulse(); tick(4);
    chk("held_issue_armed", int'(ballot_armed), 0);
    btn = 3'b000; tick(10);
    chk("timeouts_before", n_to, 0);
    issue_pulse(); tick(100);
    chk("armed_at_100", int'(ballot_armed), TO_EN ? 0 : 1);
    chk("timeouts_after", n_to, TO_EN ? 1 : 0);
    btn = 3'b001; tick(8);
    btn = 3'b000; tick(10);
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 3))
        0: issue_pulse();
        1: begin btn = 3'($urandom_range(0, 7)); tick($urandom_range(1, 10)); end
        2: begin btn = 3'b000; tick($urandom_range(1, 10)); end
        default: begin
          btn = 3'b001 << $urandom_range(0, 2);
          tick($urandom_range(1, 3));
          btn = 3'b000; tick(1);
        end
      endcase
    end
    btn = 3'b000;
    reset = 1'b1; tick(1); reset = 1'b0; tick(1);
    for (int i = 0; i < 256; i++) begin
      issue_pulse();
      btn = 3'b001 << (i % 3); tick(7);
      btn = 3'b000; tick(8);
    end
    chk("cast_saturated", int'(ballots_cast), 255);
    issue_pulse();
    btn = 3'b010; tick(10);
    reset = 1'b1; tick(1); reset = 1'b0;
    chk("midwait_reset_cast", int'(ballots_cast), 0);
    chk("midwait_reset_armed", int'(ballot_armed), 0);
    btn = 3'b000; tick(10);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
